// File: rtl/fir_coeff_sample_ctrl.sv
// Sample timebase, input-sample register and double-buffered coefficient bank
// for the 10-tap transposed FIR datapath. Coefficients swap only on a strobe.
module fir_coeff_sample_ctrl #(
    parameter int DIV     = 40,
    parameter int COEFF_W = 16
) (
    input  logic               iClk_12M,
    input  logic               iRsn,
    input  logic               iRun,
    input  logic [2:0]         iFirIn,
    input  logic               iCoeffWrEn,
    input  logic [3:0]         iCoeffAddr,
    input  logic [COEFF_W-1:0] iCoeffData,
    input  logic               iCoeffCommit,
    input  logic               iErrClr,
    output logic               oEnSample_300k,
    output logic               oEnAcc,
    output logic [2:0]         oFirIn,
    output logic [COEFF_W-1:0] oCoeff1,
    output logic [COEFF_W-1:0] oCoeff2,
    output logic [COEFF_W-1:0] oCoeff3,
    output logic [COEFF_W-1:0] oCoeff4,
    output logic [COEFF_W-1:0] oCoeff5,
    output logic [COEFF_W-1:0] oCoeff6,
    output logic [COEFF_W-1:0] oCoeff7,
    output logic [COEFF_W-1:0] oCoeff8,
    output logic [COEFF_W-1:0] oCoeff9,
    output logic [COEFF_W-1:0] oCoeff10,
    output logic               oCommitBusy,
    output logic               oWrErr
);
    localparam int NTAP = 10;
    localparam int CW   = $clog2(DIV);

    typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

    state_t                       state_q;
    logic [CW-1:0]                cnt_q, cnt_d;
    logic                         strb_q, strb_d;
    logic                         acc_q;
    logic                         pend_q, pend_d;
    logic                         err_q, err_d;
    logic [2:0]                   fir_q;
    logic [NTAP-1:0][COEFF_W-1:0] shadow_q;
    logic [NTAP-1:0][COEFF_W-1:0] act_q;
    logic                         swap, wr_hit, wr_err;

    always_comb begin
        cnt_d = '0;
        if (iRun)
            cnt_d = (cnt_q == CW'(DIV - 1)) ? '0 : cnt_q + CW'(1);
        // Strobe is registered so it lines up with the counter sitting at DIV-1.
        strb_d = (cnt_d == CW'(DIV - 1));
        swap   = strb_q && (state_q == PEND);
        wr_hit = iCoeffWrEn && !pend_q && (iCoeffAddr < 4'(NTAP));
        wr_err = iCoeffWrEn && (pend_q || (iCoeffAddr >= 4'(NTAP)));
        pend_d = pend_q;
        if (swap)
            pend_d = 1'b0;
        else if (iCoeffCommit)
            pend_d = 1'b1;
        err_d  = wr_err | (err_q & ~iErrClr);
    end

    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            strb_q   <= 1'b0;
            acc_q    <= 1'b0;
            pend_q   <= 1'b0;
            err_q    <= 1'b0;
            fir_q    <= '0;
            shadow_q <= '0;
            act_q    <= '0;
        end else begin
            cnt_q  <= cnt_d;
            strb_q <= strb_d;
            acc_q  <= strb_q;
            pend_q <= pend_d;
            err_q  <= err_d;
            if (strb_q)
                fir_q <= iFirIn;
            if (swap)
                act_q <= shadow_q;
            for (int i = 0; i < NTAP; i++)
                if (wr_hit && (iCoeffAddr == 4'(i)))
                    shadow_q[i] <= iCoeffData;
            case (state_q)
                IDLE:    if (iRun) state_q <= pend_d ? PEND : RUN;
                RUN:     if (!iRun) state_q <= IDLE;
                         else if (pend_d) state_q <= PEND;
                PEND:    if (!iRun) state_q <= IDLE;
                         else if (!pend_d) state_q <= RUN;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign oEnSample_300k = strb_q;
    assign oEnAcc         = acc_q;
    assign oFirIn         = fir_q;
    assign oCommitBusy    = pend_q;
    assign oWrErr         = err_q;
    assign oCoeff1        = act_q[0];
    assign oCoeff2        = act_q[1];
    assign oCoeff3        = act_q[2];
    assign oCoeff4        = act_q[3];
    assign oCoeff5        = act_q[4];
    assign oCoeff6        = act_q[5];
    assign oCoeff7        = act_q[6];
    assign oCoeff8        = act_q[7];
    assign oCoeff9        = act_q[8];
    assign oCoeff10       = act_q[9];
endmodule

// File: tb/tb_fir_coeff_sample_ctrl.sv
// Bench for fir_coeff_sample_ctrl: table vectors, directed corner sequences
// and random traffic against a cycle-count based reference model.
module tb_fir_coeff_sample_ctrl;
    localparam int DIV = 40;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        run = 1'b0, we = 1'b0, commit = 1'b0, clr = 1'b0;
    logic [2:0]  fir = '0;
    logic [3:0]  addr = '0;
    logic [15:0] data = '0;
    logic        o_strb, o_acc, o_busy, o_err;
    logic [2:0]  o_fir;
    logic [15:0] c1, c2, c3, c4, c5, c6, c7, c8, c9, c10;
    logic [159:0] dut_coeff;

    int errors = 0, checks = 0;

    // Reference model: strobe position derived from the length of the current run.
    int          m_runlen;
    logic        m_strb, m_acc, m_pend, m_err;
    logic [2:0]  m_fir;
    logic [15:0] m_shadow[10];
    logic [15:0] m_act[10];
    logic        last_strb, last_acc;

    fir_coeff_sample_ctrl #(.DIV(DIV), .COEFF_W(16)) dut (
        .iClk_12M(clk), .iRsn(rst_n), .iRun(run), .iFirIn(fir),
        .iCoeffWrEn(we), .iCoeffAddr(addr), .iCoeffData(data),
        .iCoeffCommit(commit), .iErrClr(clr),
        .oEnSample_300k(o_strb), .oEnAcc(o_acc), .oFirIn(o_fir),
        .oCoeff1(c1), .oCoeff2(c2), .oCoeff3(c3), .oCoeff4(c4), .oCoeff5(c5),
        .oCoeff6(c6), .oCoeff7(c7), .oCoeff8(c8), .oCoeff9(c9), .oCoeff10(c10),
        .oCommitBusy(o_busy), .oWrErr(o_err)
    );

    assign dut_coeff = {c10, c9, c8, c7, c6, c5, c4, c3, c2, c1};

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [159:0] m_pack();
        logic [159:0] p;
        for (int i = 0; i < 10; i++) p[i*16 +: 16] = m_act[i];
        return p;
    endfunction

    // First coefficient given, the rest 2..10.
    function automatic logic [159:0] seq_pack(input logic [15:0] first);
        logic [159:0] p;
        p[15:0] = first;
        for (int i = 1; i < 10; i++) p[i*16 +: 16] = 16'(i + 1);
        return p;
    endfunction

    task automatic model_reset();
        m_runlen = 0; m_strb = 0; m_acc = 0; m_pend = 0; m_err = 0; m_fir = '0;
        for (int i = 0; i < 10; i++) begin m_shadow[i] = '0; m_act[i] = '0; end
    endtask

    task automatic model_step();
        logic old_strb, old_pend, err_new;
        old_strb = m_strb;
        old_pend = m_pend;
        err_new  = 1'b0;
        m_acc = old_strb;
        if (old_strb) begin
            m_fir = fir;
            if (old_pend) for (int i = 0; i < 10; i++) m_act[i] = m_shadow[i];
        end
        if (we) begin
            if (addr > 4'd9 || old_pend) err_new = 1'b1;
            else m_shadow[addr] = data;
        end
        if (old_strb && old_pend) m_pend = 1'b0;
        else if (commit)          m_pend = 1'b1;
        m_err = err_new ? 1'b1 : (clr ? 1'b0 : m_err);
        m_runlen = run ? m_runlen + 1 : 0;
        // The k-th cycle of a run (1-based) strobes when k is a multiple of DIV.
        m_strb = run && ((m_runlen + 1) % DIV == 0);
    endtask

    task automatic cycle();
        @(negedge clk);
        last_strb = o_strb;
        last_acc  = o_acc;
        chk("strobe", o_strb, m_strb);
        chk("acc", o_acc, m_acc);
        chk("firin", o_fir, m_fir);
        chk("busy", o_busy, m_pend);
        chk("wrerr", o_err, m_err);
        chk("coeffs", dut_coeff, m_pack());
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic run_until_strobe(input int maxc, output int n);
        n = 0;
        do begin cycle(); n++; end while (!last_strb && n < maxc);
    endtask

    task automatic wait_phase(input int ph);
        int k = 0;
        while ((m_runlen % DIV) != ph && k < 200) begin cycle(); k++; end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_strb"}, o_strb, 0);
        chk({nm, "_acc"}, o_acc, 0);
        chk({nm, "_fir"}, o_fir, 0);
        chk({nm, "_coeff"}, dut_coeff, 0);
        chk({nm, "_busy"}, o_busy, 0);
        chk({nm, "_err"}, o_err, 0);
    endtask

    typedef struct {
        logic        we;
        logic [3:0]  addr;
        logic [15:0] data;
        logic        clr;
        logic        exp_err;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int n;
        tbl[0] = '{1'b1, 4'd0,  16'h0011, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 4'd12, 16'h1234, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 4'd0,  16'h0000, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 4'd15, 16'hFFFF, 1'b1, 1'b1};
        tbl[4] = '{1'b0, 4'd0,  16'h0000, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 4'd9,  16'h8000, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 4'd10, 16'h0001, 1'b0, 1'b1};
        tbl[7] = '{1'b1, 4'd2,  16'h0005, 1'b0, 1'b1};
        tbl[8] = '{1'b0, 4'd0,  16'h0000, 1'b1, 1'b0};

        model_reset();
        @(posedge clk); #1;
        chk_all_zero("reset");
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Write-error table while idle.
        for (int i = 0; i < 9; i++) begin
            we = tbl[i].we; addr = tbl[i].addr; data = tbl[i].data; clr = tbl[i].clr;
            cycle();
            we = 1'b0; clr = 1'b0;
            chk($sformatf("tbl%0d_err", i), o_err, tbl[i].exp_err);
        end

        // Free-running timebase.
        run = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            cycle();
            chk($sformatf("b_strb%0d", c), last_strb, (c % DIV) == 0);
            chk($sformatf("b_acc%0d", c), last_acc, (c > 1) && ((c - 1) % DIV == 0));
        end
        chk("b_coeff", dut_coeff, 0);

        // Load shadow 1..10, commit at counter 5, write while pending.
        for (int i = 0; i < 10; i++) begin
            we = 1'b1; addr = 4'(i); data = 16'(i + 1);
            cycle();
        end
        we = 1'b0;
        wait_phase(5);
        commit = 1'b1; cycle(); commit = 1'b0;
        chk("c_busy", o_busy, 1);
        chk("c_nochange", dut_coeff, 0);
        we = 1'b1; addr = 4'd3; data = 16'h7FFF; cycle(); we = 1'b0;
        chk("c_dropped_err", o_err, 1);
        run_until_strobe(50, n);
        chk("c_latency", n, 33);
        chk("c_swap", dut_coeff, seq_pack(16'd1));
        chk("c_coeff4", c4, 16'd4);
        chk("c_busy_clr", o_busy, 0);
        clr = 1'b1; cycle(); clr = 1'b0;
        chk("c_errclr", o_err, 0);

        // Bad address, then commit (with same-cycle write) on the strobe cycle.
        we = 1'b1; addr = 4'd12; data = 16'h1234; cycle(); we = 1'b0;
        chk("e_badaddr_err", o_err, 1);
        clr = 1'b1; cycle(); clr = 1'b0;
        wait_phase(DIV - 1);
        commit = 1'b1; we = 1'b1; addr = 4'd0; data = 16'h00AA;
        cycle();
        commit = 1'b0; we = 1'b0;
        chk("e_on_strobe", last_strb, 1);
        chk("e_busy", o_busy, 1);
        chk("e_noswap", dut_coeff, seq_pack(16'd1));
        run_until_strobe(50, n);
        chk("e_latency", n, 40);
        chk("e_swap", dut_coeff, seq_pack(16'h00AA));

        // Sample register and iRun interaction.
        fir = 3'b100;
        run_until_strobe(50, n);
        chk("f_fir_neg4", o_fir, 3'b100);
        chk("f_acc", o_acc, 1);
        fir = 3'b011;
        run_until_strobe(50, n);
        chk("f_period", n, 40);
        chk("f_fir_3", o_fir, 3'b011);
        wait_phase(20);
        run = 1'b0;
        repeat (5) cycle();
        run = 1'b1;
        run_until_strobe(50, n);
        chk("f_rerun", n, 40);
        wait_phase(DIV - 1);
        run = 1'b0; cycle();
        chk("f_acc_after_drop", o_acc, 1);
        cycle();
        chk("f_no_strb_idle", o_strb, 0);
        run = 1'b1;

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            run    = ($urandom_range(0, 19) != 0);
            we     = ($urandom_range(0, 5) == 0);
            addr   = 4'($urandom_range(0, 15));
            data   = 16'($urandom);
            commit = ($urandom_range(0, 24) == 0);
            clr    = ($urandom_range(0, 14) == 0);
            fir    = 3'($urandom);
            cycle();
        end
        we = 1'b0; commit = 1'b0; clr = 1'b0; run = 1'b1;

        // Asynchronous reset with a swap pending.
        n = 0;
        while ((m_pend || (m_runlen % DIV) != 10) && n < 300) begin cycle(); n++; end
        commit = 1'b1; cycle(); commit = 1'b0;
        repeat (3) cycle();
        chk("h_busy", o_busy, 1);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("h_async");
        model_reset();
        run = 1'b0;
        @(negedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
        run = 1'b1; we = 1'b1; addr = 4'd0; data = 16'h0055;
        cycle();
        we = 1'b0;
        chk("h_busy_after", o_busy, 0);
        run_until_strobe(50, n);
        chk("h_first_strobe", n, 39);
        cycle();
        chk("h_noswap", dut_coeff, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
